seg_frame_decoder: RTL and testbench
====================================

// Module: seg_frame_decoder
// PURPOSE
//  Receive side of the score display interface: samples a multiplexed 7-seg bus
//  (active-high segments {a,b,c,d,e,f,g}, active-low one-hot digit selects).
//  Filters each select/segment pair for stability, then decodes it back to BCD.
//  Assembles one full 4-digit frame and outputs the digits plus the binary score.
//  Used as the in-system checker/readback of what the display actually shows.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples needed before a pair is accepted (>=2)
//  NUM_DIGITS     4   digits per frame; fixed at 4 for this revision
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst_n        in   1   synchronous active-low reset
//  seg_in       in   7   segment bus {a,b,c,d,e,f,g}, 1 = segment lit
//  an_in        in   4   digit selects, active-low; an_in[i]=0 selects digit i (0 = ones)
//  digits       out  16  last complete frame, BCD {d3,d2,d1,d0}; 4'hF = invalid pattern
//  score        out  14  binary value d3*1000+d2*100+d1*10+d0 (0..9999)
//  frame_valid  out  1   one-cycle pulse when digits/score update
//  frame_err    out  1   held with each frame; 1 if any digit of that frame was invalid
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all outputs 0; sample regs, counter, seen-mask and
//    capture regs cleared; FSM -> SETTLE. Any partial frame is discarded.
//  - Stage 0: {an_in,seg_in} registered every cycle into smp; prev holds last smp.
//  - FSM SETTLE: smp==prev -> cnt++ ; smp!=prev -> cnt=0. When cnt reaches
//    STABLE_CYCLES-1 (pair held STABLE_CYCLES samples) -> ACCEPT event, go HOLD.
//  - FSM HOLD: no further accepts; smp!=prev -> cnt=0, go SETTLE. Exactly one accept
//    per stable interval, regardless of its length.
//  - On ACCEPT: an all-ones (blank) -> ignored. More than one select low -> ignored,
//    no state change. Exactly one low (bit i) -> decode seg:
//    0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//    5=1011011 6=1011111 7=1110010 8=1111111 9=1111011
//    Any other pattern -> cap[i]=4'hF and err[i]=1; else cap[i]=value, err[i]=0.
//    seen[i] set. Re-accepting digit i before frame completes overwrites cap[i]/err[i].
//  - Frame complete: the accept that makes seen==4'b1111 (cycle T):
//    T+1: digits<=cap (incl. that last digit), ferr_p<=|err, seen<=0, err<=0.
//    T+2: score<= ferr_p ? 0 : d3*1000+d2*100+d1*10+d0; frame_err<=ferr_p;
//         frame_valid=1 for this cycle only. digits stays stable until next frame.
//  - Score arithmetic: unsigned 14-bit, max 9999, no overflow possible.
//  - An accept during T+1/T+2 starts the next frame normally (pipeline does not stall).
//  - Latency: last digit stable at input -> frame_valid = STABLE_CYCLES+2 clocks
//    (1 input reg + STABLE_CYCLES-1 count + 2 pipeline).
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with random bus -> digits=0, score=0, frame_valid=0,
//    frame_err=0.
//  2 Frame: an=1110/seg=0110000, an=1101/seg=1101101, an=1011/seg=1111001,
//    an=0111/seg=0110011, each 8 cycles -> single frame_valid pulse, digits=16'h4321,
//    score=4321, frame_err=0.
//  3 Glitch: a pair held only 3 cycles between valid pairs -> not accepted, no cap
//    change; pair held exactly 4 cycles -> accepted.
//  4 Bad pattern: digit2 seg=0000001 within a frame -> digits[11:8]=4'hF, frame_err=1,
//    score=0.
//  5 Multi-select an=1100 and blank an=1111, each held 10 cycles -> no seen-mask change,
//    no frame_valid.
//  6 Reset mid-frame after 2 digits accepted -> after release, frame_valid only after
//    all 4 digits accepted again.

Source files
------------

// File: rtl/seg_frame_decoder.sv
// Readback decoder for a multiplexed 7-segment bus: debounces each select/segment
// pair, decodes it to BCD and publishes complete 4-digit frames with a binary score.
module seg_frame_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int NUM_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [13:0]             score,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int SMP_W = NUM_DIGITS + 7;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    state_t                      state_q, state_d;
    logic [SMP_W-1:0]            smp_q, prev_q;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        accept;

    logic [NUM_DIGITS-1:0]       sel, wr_en, seen_q, seen_d, err_q, err_cur;
    logic [NUM_DIGITS-1:0][3:0]  cap_q, cap_cur;
    logic                        onehot, frame_done;
    logic [3:0]                  dec_val;
    logic                        dec_ok;

    logic [4*NUM_DIGITS-1:0]     digits_q;
    logic                        ferr_p_q, valid_p_q;
    logic [13:0]                 score_q, score_d;
    logic                        frame_err_q, frame_valid_q;

    // Stability filter: accept fires once, on the STABLE_CYCLES-th identical sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            SETTLE: begin
                if (smp_q != prev_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(STABLE_CYCLES - 1);
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (smp_q != prev_q) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'hF;
        case (smp_q[6:0])
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110010: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default: begin
                dec_ok  = 1'b0;
                dec_val = 4'hF;
            end
        endcase
    end

    // Blank and multi-select pairs are dropped without touching any digit state.
    assign sel        = ~smp_q[SMP_W-1:7];
    assign onehot     = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign wr_en      = (accept && onehot) ? sel : '0;
    assign seen_d     = seen_q | wr_en;
    assign frame_done = (|wr_en) && (&seen_d);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign cap_cur[gi] = wr_en[gi] ? dec_val : cap_q[gi];
            assign err_cur[gi] = wr_en[gi] ? ~dec_ok : err_q[gi];
        end
    endgenerate

    always_comb begin
        score_d = 14'(digits_q[15:12]) * 14'd1000
                + 14'(digits_q[11:8])  * 14'd100
                + 14'(digits_q[7:4])   * 14'd10
                + 14'(digits_q[3:0]);
        if (ferr_p_q) begin
            score_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SETTLE;
            smp_q         <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            err_q         <= '0;
            cap_q         <= '0;
            digits_q      <= '0;
            ferr_p_q      <= 1'b0;
            valid_p_q     <= 1'b0;
            score_q       <= '0;
            frame_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            smp_q         <= {an_in, seg_in};
            prev_q        <= smp_q;
            cnt_q         <= cnt_d;
            cap_q         <= cap_cur;
            seen_q        <= frame_done ? '0 : seen_d;
            err_q         <= frame_done ? '0 : err_cur;
            valid_p_q     <= frame_done;
            frame_valid_q <= valid_p_q;
            if (frame_done) begin
                digits_q <= cap_cur;
                ferr_p_q <= |err_cur;
            end
            if (valid_p_q) begin
                score_q     <= score_d;
                frame_err_q <= ferr_p_q;
            end
        end
    end

    assign digits      = digits_q;
    assign score       = score_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Scoreboard bench for seg_frame_decoder: expected frames are queued as the last
// digit is driven and compared when frame_valid pulses.
module tb_seg_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [13:0] score;
    logic        frame_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;
    int frames_pushed = 0;

    typedef struct {
        logic [15:0] d;
        logic [13:0] s;
        logic        e;
        int          t0;
    } exp_t;

    exp_t sb[$];

    seg_frame_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .score       (score),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110010;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_dig(input int idx, input logic [6:0] seg, input int n);
        logic [3:0] one;
        one = 4'b0001;
        drive(~(one << idx), seg, n);
    endtask

    // Expected frame model; call right before driving the frame's last digit.
    task automatic push_frame(input int d3, input int d2, input int d1, input int d0, input logic bad2);
        exp_t e;
        e.d  = {4'(d3), (bad2 ? 4'hF : 4'(d2)), 4'(d1), 4'(d0)};
        e.e  = bad2;
        e.s  = bad2 ? 14'd0 : 14'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
        e.t0 = cyc;
        sb.push_back(e);
        frames_pushed++;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            frames_seen++;
            $display("frame: digits=%h score=%0d err=%0b at cycle %0d", digits, score, frame_err, cyc);
            if (sb.size() == 0) begin
                check_val("unexpected_frame", 32'(frame_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("digits", 32'(digits), 32'(e.d));
                check_val("score", 32'(score), 32'(e.s));
                check_val("frame_err", 32'(frame_err), 32'(e.e));
                check_val("latency", 32'(cyc - e.t0), 32'd6);
            end
        end
    end

    int frames_before;

    initial begin
        // Reset with random bus
        rst_n  = 1'b0;
        an_in  = 4'($urandom);
        seg_in = 7'($urandom);
        repeat (3) @(negedge clk);
        check_val("rst_digits", 32'(digits), 32'd0);
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_valid", 32'(frame_valid), 32'd0);
        check_val("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        drive(4'b1111, 7'd0, 6);

        // Basic frame 4321
        drive_dig(0, seg_of(1), 8);
        drive_dig(1, seg_of(2), 8);
        drive_dig(2, seg_of(3), 8);
        push_frame(4, 3, 2, 1, 1'b0);
        drive_dig(3, seg_of(4), 8);
        drive(4'b1111, 7'd0, 10);

        // 3-cycle glitch on digit 1 must not overwrite it
        drive_dig(0, seg_of(1), 8);
        drive_dig(1, seg_of(2), 8);
        drive_dig(1, seg_of(7), 3);
        drive_dig(2, seg_of(3), 8);
        push_frame(4, 3, 2, 1, 1'b0);
        drive_dig(3, seg_of(4), 8);
        drive(4'b1111, 7'd0, 10);

        // Last digit held exactly 4 cycles is accepted
        drive_dig(0, seg_of(5), 8);
        drive_dig(1, seg_of(6), 8);
        drive_dig(2, seg_of(7), 8);
        push_frame(8, 7, 6, 5, 1'b0);
        drive_dig(3, seg_of(8), 4);
        drive(4'b1111, 7'd0, 10);

        // Invalid pattern on digit 2, then a clean frame clears the error
        drive_dig(0, seg_of(1), 8);
        drive_dig(1, seg_of(2), 8);
        drive_dig(2, 7'b0000001, 8);
        push_frame(9, 0, 2, 1, 1'b1);
        drive_dig(3, seg_of(9), 8);
        drive(4'b1111, 7'd0, 10);
        drive_dig(0, seg_of(8), 8);
        drive_dig(1, seg_of(0), 8);
        drive_dig(2, seg_of(0), 8);
        push_frame(7, 0, 0, 8, 1'b0);
        drive_dig(3, seg_of(7), 8);
        drive(4'b1111, 7'd0, 10);

        // Multi-select and blank must not mark digits 0/1 as seen
        drive_dig(2, seg_of(1), 8);
        drive_dig(3, seg_of(2), 8);
        frames_before = frames_seen;
        drive(4'b1100, seg_of(8), 10);
        drive(4'b1111, seg_of(8), 10);
        check_val("multi_blank_no_frame", 32'(frames_seen), 32'(frames_before));
        drive_dig(0, seg_of(0), 8);
        push_frame(2, 1, 9, 0, 1'b0);
        drive_dig(1, seg_of(9), 8);
        drive(4'b1111, 7'd0, 10);

        // Reset mid-frame discards the partial frame
        drive_dig(0, seg_of(9), 8);
        drive_dig(1, seg_of(9), 8);
        drive(4'b1111, 7'd0, 2);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("midrst_digits", 32'(digits), 32'd0);
        check_val("midrst_score", 32'(score), 32'd0);
        rst_n = 1'b1;
        frames_before = frames_seen;
        drive_dig(2, seg_of(5), 8);
        drive_dig(3, seg_of(6), 8);
        drive(4'b1111, 7'd0, 10);
        check_val("midrst_no_frame", 32'(frames_seen), 32'(frames_before));
        drive_dig(0, seg_of(3), 8);
        push_frame(6, 5, 4, 3, 1'b0);
        drive_dig(1, seg_of(4), 8);
        drive(4'b1111, 7'd0, 20);

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        check_val("frame_count", 32'(frames_seen), 32'(frames_pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
